ctrl_fsm_mc: RTL

- Parametrised multi-cycle control unit for the 16-bit CR16-style datapath; drives the PC, register file, ALU muxes, memory port, flags and phone peripheral.
- Successor to the current fixed control FSM. Adds:
  - a configurable register count;
  - a memory ready handshake that stalls fetch, load and store;
  - JAL with link write-back;
  - a HALT state;
  - decode of undefined-range destination registers.

---
 rtl/ctrl_fsm_mc.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ctrl_fsm_mc.sv
// ctrl_fsm_mc: multi-cycle control unit for the 16-bit CR16-style datapath.
// The FSM sequences fetch, decode, execute, load/store with a memory-ready
// handshake, branch/jump/JAL, the phone peripheral strobe, and HALT.
// Outputs are decoded combinationally from the state register, so an async
// reset drops every strobe (including WE) immediately.
// Optional macro CTRL_RETIRE_CNT_EN builds a 32-bit retired-instruction counter;
// without it retire_cnt is tied to zero.
//
// state   | meaning
// --------+----------------------------------------------------------
// FETCH   | drive PC onto the address bus, wait for mem_ready
// DECODE  | load IR, classify raw instruction from data_from_mem
// EXEC    | ALU op, write rd and flags, advance PC
// STORE   | write memory at register address, wait for mem_ready
// LOAD_A  | read memory at register address, wait for mem_ready
// LOAD_WB | write loaded data to rd, advance PC
// BRANCH  | conditional PC-relative branch
// JUMP    | conditional register jump
// JAL     | unconditional jump, link PC+1 into rd
// PHONE   | strobe phone peripheral, write rd
// HALT    | core stopped until reset

module ctrl_fsm_mc #(
    parameter int          NUM_REGS = 16,
    parameter int          FLAG_W   = 5,
    parameter logic [3:0]  HALT_EXT = 4'b0001
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         instruction,
    input  logic [15:0]         data_from_mem,
    input  logic                mem_ready,
    input  logic [FLAG_W-1:0]   FLAGS,
    output logic                PCen,
    output logic [NUM_REGS-1:0] Ren,
    output logic                RegOrImm,
    output logic                WE,
    output logic [1:0]          ALU_MUX_CNTL,
    output logic                LS_CNTL,
    output logic                branch,
    output logic                jump,
    output logic                IEn,
    output logic                flagEn,
    output logic                phoneEn,
    output logic                halted,
    output logic [31:0]         retire_cnt
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC    = 4'd2,
        S_STORE   = 4'd3,
        S_LOAD_A  = 4'd4,
        S_LOAD_WB = 4'd5,
        S_BRANCH  = 4'd6,
        S_JUMP    = 4'd7,
        S_JAL     = 4'd8,
        S_PHONE   = 4'd9,
        S_HALT    = 4'd10
    } state_t;

    state_t state_q, state_d;

    logic [3:0]  dec_op, dec_ext;
    logic [3:0]  ir_op, ir_rd, ir_cond;
    logic [15:0] rd_onehot16;
    logic [NUM_REGS-1:0] rd_onehot;
    logic        cond_ok;

    assign dec_op  = data_from_mem[15:12];
    assign dec_ext = data_from_mem[7:4];
    assign ir_op   = instruction[15:12];
    assign ir_rd   = instruction[11:8];
    assign ir_cond = instruction[11:8];

    // Only the fields above are decoded; the remaining bits feed the datapath.
    logic unused_bits;
    assign unused_bits = ^{instruction[7:0], data_from_mem[11:8], data_from_mem[3:0], FLAGS};

    // Register numbers beyond NUM_REGS silently drop the write.
    assign rd_onehot16 = 16'h0001 << ir_rd;
    assign rd_onehot   = ({1'b0, ir_rd} < 5'(NUM_REGS)) ? rd_onehot16[NUM_REGS-1:0] : '0;

    // Condition evaluation; flag order is {C,L,F,Z,N} from bit 4 down.
    function automatic logic cond_true(input logic [3:0] c, input logic [4:0] f);
        logic fc, fl, ff, fz, fn;
        fc = f[4]; fl = f[3]; ff = f[2]; fz = f[1]; fn = f[0];
        case (c)
            4'h0:    cond_true = fz;
            4'h1:    cond_true = !fz;
            4'h2:    cond_true = fc;
            4'h3:    cond_true = !fc;
            4'h4:    cond_true = fl;
            4'h5:    cond_true = !fl;
            4'h6:    cond_true = fn;
            4'h7:    cond_true = !fn;
            4'h8:    cond_true = ff;
            4'h9:    cond_true = !ff;
            4'hA:    cond_true = !fl && !fz;
            4'hB:    cond_true = fl || fz;
            4'hC:    cond_true = !fn && !fz;
            4'hD:    cond_true = fn || fz;
            4'hE:    cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    endfunction

    assign cond_ok = cond_true(ir_cond, FLAGS[4:0]);

    // Next-state selection, including the decode priority chain.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (dec_op == 4'b0000 && dec_ext != 4'b0000)  state_d = S_EXEC;
                else if ({dec_op, dec_ext} == 8'b0100_0100)     state_d = S_STORE;
                else if ({dec_op, dec_ext} == 8'b0100_0000)     state_d = S_LOAD_A;
                else if ({dec_op, dec_ext} == 8'b0100_1000)     state_d = S_JAL;
                else if ({dec_op, dec_ext} == 8'b0100_1100)     state_d = S_JUMP;
                else if ({dec_op, dec_ext} == {4'b0100, HALT_EXT}) state_d = S_HALT;
                else if (dec_op == 4'b1100)                     state_d = S_BRANCH;
                else if ({dec_op, dec_ext} == 8'b1111_1111)     state_d = S_PHONE;
                else                                            state_d = S_EXEC;
            end
            S_STORE:   if (mem_ready) state_d = S_FETCH;
            S_LOAD_A:  if (mem_ready) state_d = S_LOAD_WB;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_FETCH;
        endcase
    end

    // State register; reset returns to FETCH from any wait state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Control outputs decoded from the current state.
    always_comb begin
        PCen         = 1'b0;
        Ren          = '0;
        RegOrImm     = 1'b0;
        WE           = 1'b0;
        ALU_MUX_CNTL = 2'd0;
        LS_CNTL      = 1'b0;
        branch       = 1'b0;
        jump         = 1'b0;
        IEn          = 1'b0;
        flagEn       = 1'b0;
        phoneEn      = 1'b0;
        halted       = 1'b0;
        case (state_q)
            S_FETCH:  LS_CNTL = 1'b1;
            S_DECODE: begin
                IEn     = 1'b1;
                LS_CNTL = 1'b1;
            end
            S_EXEC: begin
                PCen   = 1'b1;
                flagEn = 1'b1;
                Ren    = rd_onehot;
                case (ir_op)
                    4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7,
                    4'h9, 4'hA, 4'hB, 4'hD, 4'hF: RegOrImm = 1'b1;
                    default:                      RegOrImm = 1'b0;
                endcase
            end
            S_STORE: begin
                WE   = 1'b1;
                PCen = mem_ready;
            end
            S_LOAD_A: ;
            S_LOAD_WB: begin
                ALU_MUX_CNTL = 2'd1;
                Ren          = rd_onehot;
                PCen         = 1'b1;
            end
            S_BRANCH: begin
                PCen   = 1'b1;
                branch = cond_ok;
            end
            S_JUMP: begin
                PCen = 1'b1;
                jump = cond_ok;
            end
            S_JAL: begin
                PCen         = 1'b1;
                jump         = 1'b1;
                ALU_MUX_CNTL = 2'd2;
                Ren          = rd_onehot;
            end
            S_PHONE: begin
                PCen    = 1'b1;
                phoneEn = 1'b1;
                Ren     = rd_onehot;
            end
            S_HALT:   halted = 1'b1;
            default:  LS_CNTL = 1'b1;
        endcase
    end

`ifdef CTRL_RETIRE_CNT_EN
    logic [31:0] retire_q;

    // Count every cycle the PC advances; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       retire_q <= 32'd0;
        else if (PCen) retire_q <= retire_q + 32'd1;
    end

    assign retire_cnt = retire_q;
`else
    assign retire_cnt = 32'd0;
`endif

endmodule
